// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types, timing constants and helpers for the DRAM command scheduler.
package dram_cmd_scheduler_pkg;

    localparam int unsigned ADDRESS_WIDTH = 33;
    localparam int unsigned NUM_BG        = 4;
    localparam int unsigned BANKS_PER_BG  = 4;
    localparam int unsigned NUM_BANKS     = NUM_BG * BANKS_PER_BG;
    localparam int unsigned BG_W          = $clog2(NUM_BG);
    localparam int unsigned BANK_IDX_W    = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W         = 15;

    // Timing in CPU clock cycles
    localparam int unsigned T_RCD   = 48;
    localparam int unsigned T_RP    = 48;
    localparam int unsigned T_RAS   = 104;
    localparam int unsigned T_RC    = 152;
    localparam int unsigned T_RRD_L = 12;
    localparam int unsigned T_RRD_S = 8;
    localparam int unsigned T_CCD_L = 16;
    localparam int unsigned T_CCD_S = 8;
    localparam int unsigned T_RTP   = 24;
    localparam int unsigned T_CWD   = 40;
    localparam int unsigned T_BURST = 8;
    localparam int unsigned T_WR    = 40;
    localparam int unsigned T_WR_TO_PRE = T_CWD + T_BURST + T_WR;

    localparam int unsigned SCHED_TIMER_WIDTH = $clog2(T_RC + 1);

    typedef enum logic [1:0] {
        DATA_READ    = 2'd0,
        DATA_WRITE   = 2'd1,
        OPCODE_FETCH = 2'd2,
        NOP          = 2'd3
    } parsed_op_t;

    typedef enum logic [1:0] {
        RD  = 2'd0,
        ACT = 2'd1,
        PRE = 2'd2,
        WR  = 2'd3
    } DRAM_commands_t;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_PRE   = 3'd1,
        SCHED_ACT   = 3'd2,
        SCHED_COL   = 3'd3,
        SCHED_CLOSE = 3'd4
    } sched_state_t;

    typedef struct packed {
        DRAM_commands_t            command;
        logic [ADDRESS_WIDTH-1:0]  address;
    } queue_output_t;

    typedef logic [SCHED_TIMER_WIDTH-1:0] timer_t;

    // A constraint of n cycles loads n-1 so the dependent command may go n cycles later
    function automatic timer_t tload(input int unsigned n);
        return timer_t'(n - 1);
    endfunction

endpackage

// File: rtl/dram_cmd_scheduler_sched_countdown.sv
// Loadable saturating countdown timer; a load never shortens the remaining time.
module sched_countdown
    import dram_cmd_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  timer_t load_val,
    output timer_t count
);

    timer_t dec_c;

    assign dec_c = (count == '0) ? '0 : count - timer_t'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= (load_val > dec_c) ? load_val : dec_c;
        end else begin
            count <= dec_c;
        end
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Per-request DRAM command sequencer (PRE/ACT/RD/WR) with per-bank and per-bank-group timing.
// SCHED_OPEN_PAGE_EN selects open-page policy; default build is closed-page.
module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  parsed_op_t               req_opcode,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    output logic                     req_ready,
    output logic                     cmd_valid,
    output queue_output_t            cmd_out,
    output sched_state_t             sched_state
);

    sched_state_t             state, state_nxt, tgt;
    parsed_op_t               op_q, cur_op;
    logic [ADDRESS_WIDTH-1:0] addr_q, cur_addr;
    logic [BANK_IDX_W-1:0]    bank_idx;
    logic [BG_W-1:0]          bg;
    logic                     accept_c, is_wr;
    logic                     issue_pre, issue_act, issue_col, issue_any;
    DRAM_commands_t           cmd_c;

    timer_t pre_t [NUM_BANKS];
    timer_t act_t [NUM_BANKS];
    timer_t col_t [NUM_BANKS];
    timer_t rrd_t [NUM_BG];
    timer_t ccd_t [NUM_BG];
    timer_t pre_val, act_val;
    timer_t rrd_val [NUM_BG];
    timer_t ccd_val [NUM_BG];

    assign req_ready   = (state == SCHED_IDLE) && !rst;
    assign accept_c    = req_valid && req_ready;
    assign sched_state = state;

    // In IDLE the live request is decoded so the first command can go out right after accept
    assign cur_op   = (state == SCHED_IDLE) ? req_opcode  : op_q;
    assign cur_addr = (state == SCHED_IDLE) ? req_address : addr_q;
    assign bg       = cur_addr[7:6];
    assign bank_idx = {cur_addr[7:6], cur_addr[9:8]};
    assign is_wr    = (cur_op == DATA_WRITE);
    assign issue_any = issue_pre || issue_act || issue_col;

`ifdef SCHED_OPEN_PAGE_EN
    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_W-1:0]     open_row [NUM_BANKS];
    logic [ROW_W-1:0]     cur_row;

    assign cur_row = cur_addr[32:18];

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= '0;
            for (int i = 0; i < int'(NUM_BANKS); i++) open_row[i] <= '0;
        end else if (issue_act) begin
            bank_open[bank_idx] <= 1'b1;
            open_row[bank_idx]  <= cur_row;
        end else if (issue_pre) begin
            bank_open[bank_idx] <= 1'b0;
        end
    end
`endif

    always_comb begin
        tgt       = state;
        state_nxt = state;
        issue_pre = 1'b0;
        issue_act = 1'b0;
        issue_col = 1'b0;
        cmd_c     = RD;
        if (state == SCHED_IDLE) begin
            tgt = SCHED_IDLE;
            if (accept_c && (cur_op != NOP)) begin
`ifdef SCHED_OPEN_PAGE_EN
                if (!bank_open[bank_idx])                 tgt = SCHED_ACT;
                else if (open_row[bank_idx] == cur_row)   tgt = SCHED_COL;
                else                                      tgt = SCHED_PRE;
`else
                tgt = SCHED_ACT;
`endif
            end
        end
        case (tgt)
            SCHED_PRE: begin
                state_nxt = SCHED_PRE;
                if (pre_t[bank_idx] == '0) begin
                    issue_pre = 1'b1;
                    cmd_c     = PRE;
                    state_nxt = SCHED_ACT;
                end
            end
            SCHED_ACT: begin
                state_nxt = SCHED_ACT;
                if ((act_t[bank_idx] == '0) && (rrd_t[bg] == '0)) begin
                    issue_act = 1'b1;
                    cmd_c     = ACT;
                    state_nxt = SCHED_COL;
                end
            end
            SCHED_COL: begin
                state_nxt = SCHED_COL;
                if ((col_t[bank_idx] == '0) && (ccd_t[bg] == '0)) begin
                    issue_col = 1'b1;
                    cmd_c     = is_wr ? WR : RD;
`ifdef SCHED_OPEN_PAGE_EN
                    state_nxt = SCHED_IDLE;
`else
                    state_nxt = SCHED_CLOSE;
`endif
                end
            end
            SCHED_CLOSE: begin
                state_nxt = SCHED_CLOSE;
                if (pre_t[bank_idx] == '0) begin
                    issue_pre = 1'b1;
                    cmd_c     = PRE;
                    state_nxt = SCHED_IDLE;
                end
            end
            default: state_nxt = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCHED_IDLE;
            cmd_valid <= 1'b0;
            cmd_out   <= '0;
            op_q      <= DATA_READ;
            addr_q    <= '0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= issue_any;
            if (issue_any) begin
                cmd_out.command <= cmd_c;
                cmd_out.address <= cur_addr;
            end
            if (accept_c) begin
                op_q   <= req_opcode;
                addr_q <= req_address;
            end
        end
    end

    assign pre_val = issue_act ? tload(T_RAS) : (is_wr ? tload(T_WR_TO_PRE) : tload(T_RTP));
    assign act_val = issue_act ? tload(T_RC) : tload(T_RP);

    for (genvar i = 0; i < int'(NUM_BANKS); i++) begin : g_bank
        logic hit;
        assign hit = (bank_idx == BANK_IDX_W'(i));

        sched_countdown u_pre (
            .clk      (clk),
            .rst      (rst),
            .load     (hit && (issue_act || issue_col)),
            .load_val (pre_val),
            .count    (pre_t[i])
        );
        sched_countdown u_act (
            .clk      (clk),
            .rst      (rst),
            .load     (hit && (issue_act || issue_pre)),
            .load_val (act_val),
            .count    (act_t[i])
        );
        sched_countdown u_col (
            .clk      (clk),
            .rst      (rst),
            .load     (hit && issue_act),
            .load_val (tload(T_RCD)),
            .count    (col_t[i])
        );
    end

    // Same-group spacing uses the long constraint, other groups the short one
    for (genvar g = 0; g < int'(NUM_BG); g++) begin : g_bg
        assign rrd_val[g] = (bg == BG_W'(g)) ? tload(T_RRD_L) : tload(T_RRD_S);
        assign ccd_val[g] = (bg == BG_W'(g)) ? tload(T_CCD_L) : tload(T_CCD_S);

        sched_countdown u_rrd (
            .clk      (clk),
            .rst      (rst),
            .load     (issue_act),
            .load_val (rrd_val[g]),
            .count    (rrd_t[g])
        );
        sched_countdown u_ccd (
            .clk      (clk),
            .rst      (rst),
            .load     (issue_col),
            .load_val (ccd_val[g]),
            .count    (ccd_t[g])
        );
    end

endmodule
